fb_port_arbiter: RTL

Arbitrates the single-port framebuffer RAM between the pixel write stream produced by the image formatter (RGB565 pixel, address, valid strobe; the stream cannot be stalled) and the display scanout read path. Scanout reads have absolute priority. Writes are absorbed by an internal FIFO and retired in cycles when no read is issued. The block sits between the formatter, the scanout engine and the framebuffer RAM, and reports overflow and idle status to the image-load sequencer.

---
 rtl/fb_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM port arbiter: scanout reads always win, formatter writes are
// buffered in a FIFO and retired in cycles with no read issued.
module fb_port_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_data_valid,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    input  logic                          clear_status,
    output logic                          idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {GNT_NONE, GNT_READ, GNT_WRITE} grant_e;

    grant_e              r_grant;
    grant_e              w_grant_next;

    logic                r_rd_req;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_rd_v1;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_overflow;
    logic [15:0]         r_drop_count;

    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    // Grant uses the registered request so reads and writes both see one cycle of decision latency.
    always_comb begin
        w_grant_next = GNT_NONE;
        if (r_rd_req) begin
            w_grant_next = GNT_READ;
        end else if (r_level != '0) begin
            w_grant_next = GNT_WRITE;
        end
    end

    assign w_pop  = (w_grant_next == GNT_WRITE);
    assign w_push = wr_valid && ((r_level != FULL_LVL) || w_pop);
    assign w_drop = wr_valid && !w_push;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant <= GNT_NONE;
        end else begin
            r_grant <= w_grant_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_req    <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_rd_req  <= rd_req;
            r_rd_addr <= rd_addr;
            case (w_grant_next)
                GNT_READ: begin
                    r_mem_addr <= r_rd_addr;
                end
                GNT_WRITE: begin
                    r_mem_addr  <= r_fifo_addr[r_rd_ptr];
                    r_mem_wdata <= r_fifo_data[r_rd_ptr];
                end
                default: begin
                end
            endcase
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear_status) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_v1    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_v1    <= (r_grant == GNT_READ);
            r_rd_valid <= r_rd_v1;
            if (r_rd_v1) begin
                r_rd_data <= mem_rdata;
            end
        end
    end

    assign mem_en        = (r_grant != GNT_NONE);
    assign mem_we        = (r_grant == GNT_WRITE);
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_rd_valid;
    assign fifo_level    = r_level;
    assign overflow      = r_overflow;
    assign drop_count    = r_drop_count;
    assign idle          = (r_level == '0) && !(mem_en && mem_we);

endmodule
